// File: rtl/projectile_engine.sv
// Shared bullet pool for the shooter: spawns, moves and retires player/enemy bullets,
// detects ship hits and keeps score, health and the sticky gameover flag.
module projectile_engine #(
  parameter int NUM_SLOTS  = 8,
  parameter int X_W        = 8,
  parameter int Y_W        = 7,
  parameter int GRID_H     = 120,
  parameter int SHIP_Y     = 110,
  parameter int ENEMY_Y    = 10,
  parameter int STEP       = 2,
  parameter int HIT_HALF_W = 4,
  parameter int COOLDOWN   = 3,
  parameter int SCORE_W    = 8,
  parameter int MAX_HEALTH = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tick,
  input  logic                     shoot,
  input  logic                     enemy_fire,
  input  logic [X_W-1:0]           user_x,
  input  logic [X_W-1:0]           enemy_x,
  output logic [NUM_SLOTS-1:0]     slot_active,
  output logic [NUM_SLOTS-1:0]     slot_owner,
  output logic [NUM_SLOTS*X_W-1:0] slot_x,
  output logic [NUM_SLOTS*Y_W-1:0] slot_y,
  output logic [3:0]               gun_cooldown,
  output logic                     spawn_drop,
  output logic                     enemy_hit,
  output logic                     user_hit,
  output logic [SCORE_W-1:0]       score,
  output logic [3:0]               health,
  output logic                     gameover
);

  localparam int CNT_W     = $clog2(NUM_SLOTS + 1);
  // Enemy bullets never travel past the bottom of the playfield.
  localparam int RETIRE_DN = (SHIP_Y < GRID_H) ? SHIP_Y : GRID_H;
  localparam logic [Y_W-1:0] Y_SPAWN_UP = Y_W'(SHIP_Y - 1);
  localparam logic [Y_W-1:0] Y_SPAWN_DN = Y_W'(ENEMY_Y + 1);
  localparam logic [Y_W-1:0] Y_UP_LIM   = Y_W'(ENEMY_Y + STEP);
  localparam logic [Y_W-1:0] Y_STEP     = Y_W'(STEP);
  localparam logic [Y_W:0]   Y_DN_LIM   = (Y_W+1)'(RETIRE_DN);
  localparam logic [X_W:0]   HIT_W      = (X_W+1)'(HIT_HALF_W);

  function automatic logic [X_W:0] abs_diff(input logic [X_W-1:0] a, input logic [X_W-1:0] b);
    logic [X_W:0] ea, eb;
    ea = {1'b0, a};
    eb = {1'b0, b};
    return (ea >= eb) ? (ea - eb) : (eb - ea);
  endfunction

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a, input logic [CNT_W-1:0] n);
    logic [SCORE_W+CNT_W:0] s;
    s = (SCORE_W+CNT_W+1)'(a) + (SCORE_W+CNT_W+1)'(n);
    return (s > (SCORE_W+CNT_W+1)'({SCORE_W{1'b1}})) ? {SCORE_W{1'b1}} : s[SCORE_W-1:0];
  endfunction

  function automatic logic [3:0] sat_sub(input logic [3:0] h, input logic [CNT_W-1:0] n);
    logic [CNT_W+3:0] eh, en;
    eh = (CNT_W+4)'(h);
    en = (CNT_W+4)'(n);
    return (en >= eh) ? 4'd0 : 4'(eh - en);
  endfunction

  logic [NUM_SLOTS-1:0] active_q, active_d, owner_q, owner_d, free;
  logic [X_W-1:0]       x_q [NUM_SLOTS];
  logic [X_W-1:0]       x_d [NUM_SLOTS];
  logic [Y_W-1:0]       y_q [NUM_SLOTS];
  logic [Y_W-1:0]       y_d [NUM_SLOTS];
  logic [3:0]           cd_q, cd_d, health_q, health_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic                 drop_q, drop_d, ehit_q, ehit_d, uhit_q, uhit_d, over_q, over_d;
  logic [CNT_W-1:0]     e_cnt, u_cnt;
  logic [Y_W:0]         y_dn;
  logic                 tick_en, p_req, e_req, p_ok, e_ok;

  always_comb begin
    active_d = active_q;
    owner_d  = owner_q;
    x_d      = x_q;
    y_d      = y_q;
    cd_d     = cd_q;
    score_d  = score_q;
    health_d = health_q;
    over_d   = over_q;
    drop_d   = 1'b0;
    ehit_d   = 1'b0;
    uhit_d   = 1'b0;
    e_cnt    = '0;
    u_cnt    = '0;
    y_dn     = '0;
    p_ok     = 1'b0;
    e_ok     = 1'b0;
    free     = ~active_q;
    tick_en  = tick && !over_q;
    p_req    = shoot && (cd_q == 4'd0) && !over_q;
    e_req    = enemy_fire && !over_q;

    // Movement works only on slots active before this clk, so fresh spawns stay put.
    if (tick_en) begin
      if (cd_q != 4'd0) cd_d = cd_q - 4'd1;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (active_q[i]) begin
          if (!owner_q[i]) begin
            if (y_q[i] <= Y_UP_LIM) begin
              active_d[i] = 1'b0;
              if (abs_diff(x_q[i], enemy_x) <= HIT_W) e_cnt = e_cnt + CNT_W'(1);
            end else begin
              y_d[i] = y_q[i] - Y_STEP;
            end
          end else begin
            y_dn = {1'b0, y_q[i]} + (Y_W+1)'(STEP);
            if (y_dn >= Y_DN_LIM) begin
              active_d[i] = 1'b0;
              if (abs_diff(x_q[i], user_x) <= HIT_W) u_cnt = u_cnt + CNT_W'(1);
            end else begin
              y_d[i] = y_dn[Y_W-1:0];
            end
          end
        end
      end
      ehit_d   = (e_cnt != '0);
      uhit_d   = (u_cnt != '0);
      score_d  = sat_add(score_q, e_cnt);
      health_d = sat_sub(health_q, u_cnt);
      over_d   = (health_d == 4'd0);
    end

    // Player claims the lowest free slot first; retiring slots are not yet free.
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (p_req && !p_ok && free[i]) begin
        p_ok        = 1'b1;
        free[i]     = 1'b0;
        active_d[i] = 1'b1;
        owner_d[i]  = 1'b0;
        x_d[i]      = user_x;
        y_d[i]      = Y_SPAWN_UP;
      end
    end
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (e_req && !e_ok && free[i]) begin
        e_ok        = 1'b1;
        free[i]     = 1'b0;
        active_d[i] = 1'b1;
        owner_d[i]  = 1'b1;
        x_d[i]      = enemy_x;
        y_d[i]      = Y_SPAWN_DN;
      end
    end
    if (p_ok) cd_d = 4'(COOLDOWN);
    drop_d = (p_req && !p_ok) || (e_req && !e_ok);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_q <= '0;
      owner_q  <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
      cd_q     <= 4'd0;
      score_q  <= '0;
      health_q <= 4'(MAX_HEALTH);
      over_q   <= 1'b0;
      drop_q   <= 1'b0;
      ehit_q   <= 1'b0;
      uhit_q   <= 1'b0;
    end else begin
      active_q <= active_d;
      owner_q  <= owner_d;
      x_q      <= x_d;
      y_q      <= y_d;
      cd_q     <= cd_d;
      score_q  <= score_d;
      health_q <= health_d;
      over_q   <= over_d;
      drop_q   <= drop_d;
      ehit_q   <= ehit_d;
      uhit_q   <= uhit_d;
    end
  end

  always_comb begin
    slot_x = '0;
    slot_y = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      slot_x[i*X_W +: X_W] = x_q[i];
      slot_y[i*Y_W +: Y_W] = y_q[i];
    end
  end

  assign slot_active  = active_q;
  assign slot_owner   = owner_q;
  assign gun_cooldown = cd_q;
  assign spawn_drop   = drop_q;
  assign enemy_hit    = ehit_q;
  assign user_hit     = uhit_q;
  assign score        = score_q;
  assign health       = health_q;
  assign gameover     = over_q;

endmodule

// File: tb/tb_projectile_engine.sv
// Directed bench for projectile_engine: default instance plus a zero-cooldown
// instance used to land two player bullets on the same tick.
module tb_projectile_engine;
  localparam int NS = 8;
  localparam int XW = 8;
  localparam int YW = 7;
  localparam int SW = 8;

  logic clk = 1'b0, reset = 1'b0, tick = 1'b0, shoot = 1'b0, enemy_fire = 1'b0;
  logic shoot2 = 1'b0, fire2 = 1'b0;
  logic [XW-1:0] user_x = '0, enemy_x = '0;

  logic [NS-1:0] act, own, act2, own2;
  logic [NS*XW-1:0] sx, sx2;
  logic [NS*YW-1:0] sy, sy2;
  logic [3:0] cd, cd2, hp, hp2;
  logic drop, ehit, uhit, over, drop2, ehit2, uhit2, over2;
  logic [SW-1:0] score, score2;

  int n_cmp = 0;
  int n_err = 0;

  projectile_engine #(.NUM_SLOTS(NS), .X_W(XW), .Y_W(YW), .COOLDOWN(3), .SCORE_W(SW)) dut (
    .clk(clk), .reset(reset), .tick(tick), .shoot(shoot), .enemy_fire(enemy_fire),
    .user_x(user_x), .enemy_x(enemy_x), .slot_active(act), .slot_owner(own),
    .slot_x(sx), .slot_y(sy), .gun_cooldown(cd), .spawn_drop(drop),
    .enemy_hit(ehit), .user_hit(uhit), .score(score), .health(hp), .gameover(over));

  projectile_engine #(.NUM_SLOTS(NS), .X_W(XW), .Y_W(YW), .COOLDOWN(0), .SCORE_W(SW)) dut2 (
    .clk(clk), .reset(reset), .tick(tick), .shoot(shoot2), .enemy_fire(fire2),
    .user_x(user_x), .enemy_x(enemy_x), .slot_active(act2), .slot_owner(own2),
    .slot_x(sx2), .slot_y(sy2), .gun_cooldown(cd2), .spawn_drop(drop2),
    .enemy_hit(ehit2), .user_hit(uhit2), .score(score2), .health(hp2), .gameover(over2));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] gx(input logic [NS*XW-1:0] v, input int i);
    return 32'(v[i*XW +: XW]);
  endfunction

  function automatic logic [31:0] gy(input logic [NS*YW-1:0] v, input int i);
    return 32'(v[i*YW +: YW]);
  endfunction

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    clk1();
    tick = 1'b0;
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    // reset values
    clk1();
    clk1();
    chk("rst_active", 32'(act), 32'h0);
    chk("rst_cooldown", 32'(cd), 32'd0);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_health", 32'(hp), 32'd3);
    chk("rst_gameover", 32'(over), 32'd0);
    chk("rst_drop", 32'(drop), 32'd0);
    reset = 1'b1;
    clk1();

    // player shot flies up and hits the enemy on the 50th tick
    user_x = 8'd80; enemy_x = 8'd80; shoot = 1'b1;
    clk1();
    shoot = 1'b0;
    chk("p_spawn_active", 32'(act), 32'h01);
    chk("p_spawn_x", gx(sx, 0), 32'd80);
    chk("p_spawn_y", gy(sy, 0), 32'd109);
    chk("p_spawn_cd", 32'(cd), 32'd3);
    repeat (49) do_tick();
    chk("p_t49_y", gy(sy, 0), 32'd11);
    chk("p_t49_cd", 32'(cd), 32'd0);
    do_tick();
    chk("p_t50_active", 32'(act), 32'h0);
    chk("p_t50_ehit", 32'(ehit), 32'd1);
    chk("p_t50_score", 32'(score), 32'd1);
    clk1();
    chk("p_ehit_pulse", 32'(ehit), 32'd0);

    // enemy shot flies down and hits the player
    user_x = 8'd40; enemy_x = 8'd40; enemy_fire = 1'b1;
    clk1();
    enemy_fire = 1'b0;
    chk("e_spawn_owner", 32'(own), 32'h01);
    chk("e_spawn_y", gy(sy, 0), 32'd11);
    chk("e_spawn_x", gx(sx, 0), 32'd40);
    repeat (49) do_tick();
    chk("e_t49_y", gy(sy, 0), 32'd109);
    do_tick();
    chk("e_t50_uhit", 32'(uhit), 32'd1);
    chk("e_t50_health", 32'(hp), 32'd2);
    chk("e_t50_active", 32'(act), 32'h0);

    // five columns away is a miss
    enemy_x = 8'd45; enemy_fire = 1'b1;
    clk1();
    enemy_fire = 1'b0;
    repeat (50) do_tick();
    chk("miss_uhit", 32'(uhit), 32'd0);
    chk("miss_health", 32'(hp), 32'd2);
    chk("miss_active", 32'(act), 32'h0);

    // nine enemy shots with no ticks: ninth is dropped
    do_reset();
    enemy_x = 8'd200; enemy_fire = 1'b1;
    repeat (8) clk1();
    chk("fill_active", 32'(act), 32'hFF);
    chk("fill_drop", 32'(drop), 32'd0);
    clk1();
    enemy_fire = 1'b0;
    chk("full_drop", 32'(drop), 32'd1);
    chk("full_active", 32'(act), 32'hFF);
    chk("full_y7", gy(sy, 7), 32'd11);
    clk1();
    chk("drop_pulse", 32'(drop), 32'd0);

    // one free slot, both request: player wins
    do_reset();
    enemy_fire = 1'b1;
    repeat (7) clk1();
    chk("seven_active", 32'(act), 32'h7F);
    user_x = 8'd60; shoot = 1'b1;
    clk1();
    shoot = 1'b0; enemy_fire = 1'b0;
    chk("race_active", 32'(act), 32'hFF);
    chk("race_owner", 32'(own), 32'h7F);
    chk("race_x7", gx(sx, 7), 32'd60);
    chk("race_cd", 32'(cd), 32'd3);
    chk("race_drop", 32'(drop), 32'd1);

    // shoot held through 10 ticks: one shot per 3 ticks
    do_reset();
    user_x = 8'd100; shoot = 1'b1;
    clk1();
    chk("hold_first", 32'(act), 32'h01);
    for (int k = 1; k <= 10; k++) begin
      do_tick();
      clk1();
      if (k == 2) chk("hold_k2", 32'(act), 32'h01);
    end
    shoot = 1'b0;
    chk("hold_active", 32'(act), 32'h0F);
    chk("hold_cd", 32'(cd), 32'd2);
    chk("hold_y0", gy(sy, 0), 32'd89);
    chk("hold_y1", gy(sy, 1), 32'd95);
    chk("hold_y3", gy(sy, 3), 32'd107);

    // two player bullets hit on the same tick, both at the |dx|==4 edge
    do_reset();
    enemy_x = 8'd80; user_x = 8'd76; shoot2 = 1'b1;
    clk1();
    user_x = 8'd84;
    clk1();
    shoot2 = 1'b0;
    chk("dbl_active", 32'(act2), 32'h03);
    repeat (50) do_tick();
    chk("dbl_score", 32'(score2), 32'd2);
    chk("dbl_ehit", 32'(ehit2), 32'd1);
    chk("dbl_active_end", 32'(act2), 32'h0);

    // three simultaneous enemy hits end the game
    do_reset();
    user_x = 8'd40; enemy_x = 8'd40; enemy_fire = 1'b1;
    repeat (3) clk1();
    enemy_fire = 1'b0;
    chk("go_spawn", 32'(act), 32'h07);
    repeat (10) do_tick();
    user_x = 8'd200; shoot = 1'b1;
    clk1();
    shoot = 1'b0; user_x = 8'd40;
    chk("go_pshot", 32'(act), 32'h0F);
    repeat (39) do_tick();
    chk("go_t49_health", 32'(hp), 32'd3);
    do_tick();
    chk("go_health", 32'(hp), 32'd0);
    chk("go_flag", 32'(over), 32'd1);
    chk("go_uhit", 32'(uhit), 32'd1);
    chk("go_active", 32'(act), 32'h08);
    chk("go_y3", gy(sy, 3), 32'd29);
    shoot = 1'b1; enemy_fire = 1'b1; tick = 1'b1;
    repeat (3) clk1();
    shoot = 1'b0; enemy_fire = 1'b0; tick = 1'b0;
    chk("frz_active", 32'(act), 32'h08);
    chk("frz_y3", gy(sy, 3), 32'd29);
    chk("frz_uhit", 32'(uhit), 32'd0);
    chk("frz_drop", 32'(drop), 32'd0);
    chk("frz_health", 32'(hp), 32'd0);
    chk("frz_flag", 32'(over), 32'd1);

    // asynchronous reset mid-flight
    #2 reset = 1'b0;
    #1;
    chk("arst_active", 32'(act), 32'h0);
    chk("arst_y3", gy(sy, 3), 32'd0);
    chk("arst_health", 32'(hp), 32'd3);
    chk("arst_flag", 32'(over), 32'd0);
    clk1();
    reset = 1'b1;
    clk1();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
